lookup_cfg_seq: RTL

LOOKUP_CFG_SEQ -- requirements
Module: lookup_cfg_seq

---
 rtl/lookup_cfg_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lookup_cfg_seq.sv
// Sequences one match/action config entry into the lookup tables while the lookup path is quiesced.
// Latency: accept at T -> match write T+2 -> action write T+3 -> cfg_done T+4 -> ready again T+5 (minimum).
// Backpressure: cfg_ready only in IDLE; stall holds the key extractor while draining and writing.
module lookup_cfg_seq #(
  parameter int STAGE   = 0,
  parameter int KEY_LEN = 197,
  parameter int ACT_W   = 625,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_stage,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [KEY_LEN-1:0] cfg_key,
  input  logic [KEY_LEN-1:0] cfg_mask,
  input  logic [ACT_W-1:0]   cfg_action,
  input  logic               key_valid,
  input  logic               action_valid,
  output logic               stall,
  output logic [KEY_LEN-1:0] lookup_din,
  output logic [KEY_LEN-1:0] lookup_din_mask,
  output logic [ADDR_W-1:0]  lookup_din_addr,
  output logic               lookup_din_en,
  output logic [ACT_W-1:0]   action_data_in,
  output logic [ADDR_W-1:0]  action_addr,
  output logic               action_en,
  output logic               cfg_done,
  output logic               cfg_drop,
  output logic               err
);

  localparam logic [3:0] STAGE_ID = 4'(STAGE);

  typedef enum logic [2:0] {IDLE, DRAIN, WR_KEY, WR_ACT, DONE} state_t;

  state_t             state, next_state;
  logic [3:0]         outstanding;
  logic [7:0]         drain_timer;
  logic [ADDR_W-1:0]  addr_q;
  logic [KEY_LEN-1:0] key_q;
  logic [KEY_LEN-1:0] mask_q;
  logic [ACT_W-1:0]   action_q;
  logic [3:0]         stage_q;
  logic               drop_q;
  logic               err_q;
  logic               accept;
  logic               stage_hit;
  logic               stall_int;
  logic               timeout;

  // Handshake decode; stage_q is kept only so all entry fields stay latched together.
  assign accept    = cfg_valid && (state == IDLE) && !rst;
  assign stage_hit = (cfg_stage == STAGE_ID);
  assign stall_int = (state == DRAIN) || (state == WR_KEY) || (state == WR_ACT);
  assign timeout   = (state == DRAIN) && (drain_timer == 8'hff);

  // Next-state logic and state-decoded outputs; everything is forced low while rst is high.
  always_comb begin
    next_state      = state;
    cfg_ready       = 1'b0;
    stall           = 1'b0;
    lookup_din_en   = 1'b0;
    action_en       = 1'b0;
    cfg_done        = 1'b0;
    lookup_din      = '0;
    lookup_din_mask = '0;
    lookup_din_addr = '0;
    action_data_in  = '0;
    action_addr     = '0;
    case (state)
      IDLE:   if (accept && stage_hit) next_state = DRAIN;
      DRAIN:  if (timeout || (outstanding == 4'd0 && !key_valid)) next_state = WR_KEY;
      WR_KEY: next_state = WR_ACT;
      WR_ACT: next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rst) begin
      cfg_ready = (state == IDLE);
      stall     = stall_int;
      cfg_done  = (state == DONE);
      if (state == WR_KEY) begin
        lookup_din_en   = 1'b1;
        lookup_din      = key_q;
        lookup_din_mask = mask_q;
        lookup_din_addr = addr_q;
      end
      if (state == WR_ACT) begin
        action_en      = 1'b1;
        action_data_in = action_q;
        action_addr    = addr_q;
      end
    end
  end

  assign cfg_drop = drop_q && !rst;
  assign err      = err_q && !rst;

  // State register; reset aborts any write sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Entry latch and one-cycle drop pulse for entries aimed at another stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      key_q    <= '0;
      mask_q   <= '0;
      action_q <= '0;
      stage_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= accept && !stage_hit;
      if (accept) begin
        addr_q   <= cfg_addr;
        key_q    <= cfg_key;
        mask_q   <= cfg_mask;
        action_q <= cfg_action;
        stage_q  <= cfg_stage;
      end
    end
  end

  // Outstanding-lookup counter, saturating at both ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= 4'd0;
    end else if (key_valid && !action_valid && outstanding != 4'd15) begin
      outstanding <= outstanding + 4'd1;
    end else if (action_valid && !key_valid && outstanding != 4'd0) begin
      outstanding <= outstanding - 4'd1;
    end
  end

  // Drain watchdog: restarts at zero on every DRAIN entry.
  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) drain_timer <= 8'd0;
    else                       drain_timer <= drain_timer + 8'd1;
  end

  // Sticky error: counter over/underflow, key issued while stalled, or drain timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((key_valid && !action_valid && outstanding == 4'd15) ||
                 (action_valid && !key_valid && outstanding == 4'd0) ||
                 (key_valid && stall_int) || timeout) begin
      err_q <= 1'b1;
    end
  end

endmodule
